// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the hh:mm:ss countdown timer.
// Field width covers 0..63; every field is clamped well below that.
package countdown_timer_pkg;

  localparam int unsigned FIELD_W = 6;

  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  function automatic logic [FIELD_W-1:0] clamp_field(
    input logic [FIELD_W-1:0] val,
    input logic [FIELD_W-1:0] max_val
  );
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/countdown_field.sv
// One time field (secs, mins or hours): clamped load, decrement with wrap to MAX_VAL.
// Value updates one cycle after load/dec; borrow_o is combinational so the chain settles in one cycle.
module countdown_field
  import countdown_timer_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX_VAL = SEC_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_i,
  input  logic               load_i,
  input  logic [FIELD_W-1:0] load_val_i,
  output logic [FIELD_W-1:0] value_o,
  output logic               zero_o,
  output logic               borrow_o
);

  logic [FIELD_W-1:0] value_q;
  logic [FIELD_W-1:0] value_d;

  assign zero_o   = (value_q == '0);
  // Decrementing a zero field wraps it and asks the next field up for a borrow.
  assign borrow_o = dec_i & zero_o;
  assign value_o  = value_q;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = clamp_field(load_val_i, MAX_VAL);
    end else if (dec_i) begin
      value_d = zero_o ? MAX_VAL : (value_q - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// hh:mm:ss countdown timer with load/start/pause control and a one-cycle Done pulse.
// All outputs registered; a Tick in RUN is visible on the next edge. Load beats Start/Pause.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned MAX_HOURS = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               load_i,
  input  logic [FIELD_W-1:0] ld_hours_i,
  input  logic [FIELD_W-1:0] ld_mins_i,
  input  logic [FIELD_W-1:0] ld_secs_i,
  input  logic               start_i,
  input  logic               pause_i,
  output logic [FIELD_W-1:0] hours_o,
  output logic [FIELD_W-1:0] mins_o,
  output logic [FIELD_W-1:0] secs_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [FIELD_W-1:0] HOUR_MAX = FIELD_W'(MAX_HOURS);

  state_e state_q, state_d;
  logic   busy_q, done_q, done_d;
  logic   run_tick;

  logic secs_zero, mins_zero, hours_zero;
  logic secs_borrow, mins_borrow, hours_borrow;
  logic all_zero, count_one;

  assign all_zero  = secs_zero & mins_zero & hours_zero;
  assign count_one = mins_zero & hours_zero & (secs_o == 6'd1);

  countdown_field #(.MAX_VAL(SEC_MAX)) u_secs (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_i      (run_tick & ~all_zero),
    .load_i     (load_i),
    .load_val_i (ld_secs_i),
    .value_o    (secs_o),
    .zero_o     (secs_zero),
    .borrow_o   (secs_borrow)
  );

  countdown_field #(.MAX_VAL(MIN_MAX)) u_mins (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_i      (secs_borrow),
    .load_i     (load_i),
    .load_val_i (ld_mins_i),
    .value_o    (mins_o),
    .zero_o     (mins_zero),
    .borrow_o   (mins_borrow)
  );

  countdown_field #(.MAX_VAL(HOUR_MAX)) u_hours (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_i      (mins_borrow),
    .load_i     (load_i),
    .load_val_i (ld_hours_i),
    .value_o    (hours_o),
    .zero_o     (hours_zero),
    .borrow_o   (hours_borrow)
  );

  // The all_zero guard on the seconds decrement means the hours field can never borrow.
  assert property (@(posedge clk) disable iff (!rst_n) !hours_borrow);

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    run_tick = 1'b0;
    if (load_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_PAUSED: begin
          if (start_i) begin
            if (all_zero) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Pause wins over both Start and a coincident Tick: the count freezes as-is.
          if (pause_i) begin
            state_d = ST_PAUSED;
          end else if (tick_i) begin
            run_tick = 1'b1;
            if (count_one) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed checks of countdown_timer against a total-seconds reference model.
module tb_countdown_timer;

  localparam int MAXH     = 23;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_EXP    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_i = 1'b0, load_i = 1'b0, start_i = 1'b0, pause_i = 1'b0;
  logic [5:0] ld_hours_i = '0, ld_mins_i = '0, ld_secs_i = '0;
  logic [5:0] hours_o, mins_o, secs_o;
  logic       busy_o, done_o;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining time as plain seconds plus a mode.
  int   m_secs = 0;
  int   m_mode = M_IDLE;
  logic m_done = 1'b0;

  countdown_timer #(.MAX_HOURS(MAXH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_i),
    .load_i     (load_i),
    .ld_hours_i (ld_hours_i),
    .ld_mins_i  (ld_mins_i),
    .ld_secs_i  (ld_secs_i),
    .start_i    (start_i),
    .pause_i    (pause_i),
    .hours_o    (hours_o),
    .mins_o     (mins_o),
    .secs_o     (secs_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lim(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    m_secs = 0;
    m_mode = M_IDLE;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (load_i) begin
      m_secs = lim(int'(ld_hours_i), MAXH) * 3600 + lim(int'(ld_mins_i), 59) * 60
             + lim(int'(ld_secs_i), 59);
      m_mode = M_IDLE;
    end else if ((m_mode == M_IDLE || m_mode == M_PAUSED) && start_i) begin
      if (m_secs == 0) begin
        m_mode = M_EXP;
        m_done = 1'b1;
      end else begin
        m_mode = M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      if (pause_i) begin
        m_mode = M_PAUSED;
      end else if (tick_i) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = M_EXP;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/hours"}, 32'(hours_o), 32'(m_secs / 3600));
    chk({tag, "/mins"},  32'(mins_o),  32'((m_secs / 60) % 60));
    chk({tag, "/secs"},  32'(secs_o),  32'(m_secs % 60));
    chk({tag, "/busy"},  32'(busy_o),  32'(m_mode == M_RUN));
    chk({tag, "/done"},  32'(done_o),  32'(m_done));
  endtask

  // Drive one cycle of inputs, clock it, update the model, then compare.
  task automatic cyc(input string tag, input logic ld, input logic st, input logic pa,
                     input logic tk, input int hh = 0, input int mm = 0, input int ss = 0);
    load_i = ld; start_i = st; pause_i = pa; tick_i = tk;
    ld_hours_i = 6'(hh); ld_mins_i = 6'(mm); ld_secs_i = 6'(ss);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    load_i = 1'b0; start_i = 1'b0; pause_i = 1'b0; tick_i = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    #4 rst_n = 1'b1;

    // Simple decrement with Busy held.
    cyc("r30_load", 1, 0, 0, 0, 0, 1, 2);
    cyc("r30_start", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("r30_tick", 0, 0, 0, 1);
    chk("r30_final", 32'({hours_o, mins_o, secs_o}), 32'({6'd0, 6'd0, 6'd59}));

    // Hour borrow, then expiry and EXPIRED hold.
    cyc("r31_load", 1, 0, 0, 0, 1, 0, 0);
    cyc("r31_start", 0, 1, 0, 0);
    cyc("r31_borrow", 0, 0, 0, 1);
    chk("r31_borrow_val", 32'({hours_o, mins_o, secs_o}), 32'({6'd0, 6'd59, 6'd59}));
    cyc("r31_load2", 1, 0, 0, 0, 0, 0, 2);
    cyc("r31_start2", 0, 1, 0, 0);
    cyc("r31_t1", 0, 0, 0, 1);
    cyc("r31_t0", 0, 0, 0, 1);
    chk("r31_done_pulse", 32'(done_o), 32'd1);
    for (int i = 0; i < 3; i++) cyc("r31_hold", 0, 1, 1, 1);
    chk("r31_done_low", 32'(done_o), 32'd0);

    // Clamping; Load beats Start.
    cyc("r32_clamp", 1, 0, 0, 0, 40, 61, 63);
    chk("r32_clamp_val", 32'({hours_o, mins_o, secs_o}), 32'({6'd23, 6'd59, 6'd59}));
    cyc("r32_load_start", 1, 1, 1, 1, 40, 61, 63);
    chk("r32_busy", 32'(busy_o), 32'd0);
    cyc("r32_idle_tick", 0, 0, 0, 1);

    // Pause freezes, Start resumes; Start+Pause in PAUSED acts as Start.
    cyc("r33_load", 1, 0, 0, 0, 0, 0, 10);
    cyc("r33_start", 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc("r33_tick", 0, 0, 0, 1);
    cyc("r33_pause", 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc("r33_ptick", 0, 0, 0, 1);
    chk("r33_hold", 32'(secs_o), 32'd8);
    cyc("r33_resume", 0, 1, 1, 0);
    cyc("r33_tick2", 0, 0, 0, 1);
    chk("r33_after", 32'(secs_o), 32'd7);

    // Start on a zero count.
    cyc("r34_load", 1, 0, 0, 0, 0, 0, 0);
    cyc("r34_start", 0, 1, 0, 0);
    chk("r34_done", 32'(done_o), 32'd1);
    cyc("r34_after", 0, 1, 0, 1);

    // Asynchronous reset mid-RUN.
    cyc("r35_load", 1, 0, 0, 0, 0, 0, 5);
    cyc("r35_start", 0, 1, 0, 0);
    tick_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("r35_async");
    @(posedge clk);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc("r35_post", 0, 0, 0, 1);

    // Random traffic, biased towards short counts so expiry is common.
    for (int n = 0; n < 3000; n++) begin
      logic ld, st, pa, tk;
      int   hh, mm, ss;
      ld = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 12);
      pa = ($urandom_range(0, 99) < 6);
      tk = pa ? 1'b0 : ($urandom_range(0, 99) < 60);
      hh = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
      mm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 2));
      ss = int'($urandom_range(0, 63));
      cyc("rand", ld, st, pa, tk, hh, mm, ss);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MAX_HOURS, default 23, is the largest hour value accepted on load.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 Tick  input  1  count-enable strobe; one decrement per CLK cycle with Tick=1 while running.
REQ-005 Load  input  1  single-cycle request to load LdHours/LdMins/LdSecs.
REQ-006 LdHours, LdMins, LdSecs  input  6 each  preset time value.
REQ-007 Start  input  1  single-cycle request to begin or resume counting.
REQ-008 Pause  input  1  single-cycle request to suspend counting.
REQ-009 Hours, Mins, Secs  output  6 each  remaining time, registered.
REQ-010 Busy  output  1  high in RUN state only.
REQ-011 Done  output  1  one-cycle pulse when the count reaches 00:00:00.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, PAUSED, EXPIRED.
REQ-013 Load SHALL, in any state, write clamped values on the next edge: Secs=min(LdSecs,59), Mins=min(LdMins,59), Hours=min(LdHours,MAX_HOURS), and go to IDLE.
REQ-014 Load SHALL take priority over Start and Pause asserted in the same cycle; the latter are ignored.
REQ-015 Start in IDLE or PAUSED with non-zero count SHALL enter RUN next cycle; with a zero count it SHALL enter EXPIRED and pulse Done next cycle.
REQ-016 Start in RUN or EXPIRED SHALL be ignored.
REQ-017 Pause in RUN SHALL enter PAUSED next cycle with the count frozen; Pause in any other state is ignored.
REQ-018 Start and Pause both asserted in RUN SHALL be treated as Pause; in PAUSED as Start.
REQ-019 In RUN with Tick=1 the count SHALL decrement by one second with borrow: Secs>0 -> Secs-1; Secs=0,Mins>0 -> Secs=59,Mins-1; Secs=0,Mins=0,Hours>0 -> Secs=59,Mins=59,Hours-1.
REQ-020 Tick in IDLE, PAUSED or EXPIRED SHALL not change the count.
REQ-021 A Tick in RUN taking the count from 00:00:01 to 00:00:00 SHALL move to EXPIRED and assert Done for exactly that following cycle (the cycle the outputs first read 00:00:00).
REQ-022 EXPIRED SHALL hold 00:00:00, Done low after its pulse, until Load or reset.
REQ-023 Decrement latency SHALL be one cycle: outputs reflect the Tick on the next edge.
REQ-024 Fields SHALL never hold values above 59/59/MAX_HOURS and SHALL never underflow.

Reset
REQ-025 RST_N low SHALL immediately force IDLE, Hours=Mins=Secs=0, Busy=0, Done=0, irrespective of CLK.
REQ-026 Reset asserted mid-RUN SHALL abandon the count with no Done pulse; after release the block stays IDLE until Load/Start.

Structure
REQ-027 A shared package SHALL hold the state encoding typedef and constants SEC_MAX=59, MIN_MAX=59.
REQ-028 One sub-module, countdown_field, SHALL implement a single field with parameterised maximum: inputs dec, load, load value; outputs value, zero flag, borrow-out; instantiated three times.
REQ-029 Done and Busy SHALL be registered outputs.

Verification
REQ-030 Load 00:01:02, Start, 3 Ticks -> 00:01:01, 00:01:00, 00:00:59; Busy=1 throughout.
REQ-031 Load 01:00:00, Start, 1 Tick -> 00:59:59; Load 00:00:02, Start, 2 Ticks -> 00:00:00, Done high one cycle, state EXPIRED, further Ticks no change.
REQ-032 Load LdHours=40, LdMins=61, LdSecs=63 -> outputs 23:59:59; Start with Load same cycle -> stays IDLE, Busy=0.
REQ-033 Load 00:00:10, Start, 2 Ticks, Pause, 5 Ticks -> holds 00:00:08, Busy=0; Start, 1 Tick -> 00:00:07.
REQ-034 Load 00:00:00, Start -> EXPIRED next cycle with one-cycle Done pulse.
REQ-035 Load 00:00:05, Start, RST_N low between edges -> outputs 00:00:00, Busy=0 immediately, no Done pulse after release.
